// File: rtl/i2c_txn_sequencer_if.sv
// Bundles the host command/response channels and the i2c_master command bus
// seen by i2c_txn_sequencer; slave is the sequencer's view, master the surroundings'.
interface i2c_txn_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rw;
  logic [6:0]        cmd_chip_addr;
  logic [7:0]        cmd_reg_addr;
  logic [DATA_W-1:0] cmd_data;
  logic [LVL_W-1:0]  cmd_level;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_status;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        rsp_retries;

  logic [6:0]        m_chip_addr;
  logic [7:0]        m_reg_addr;
  logic [DATA_W-1:0] m_data_in;
  logic              m_write_en;
  logic              m_read_en;
  logic              m_busy;
  logic              m_done;
  logic [3:0]        m_status;
  logic [DATA_W-1:0] m_data_out;

  modport slave (
    input  cmd_valid, cmd_rw, cmd_chip_addr, cmd_reg_addr, cmd_data,
    output cmd_ready, cmd_level,
    output rsp_valid, rsp_status, rsp_data, rsp_retries,
    input  rsp_ready,
    output m_chip_addr, m_reg_addr, m_data_in, m_write_en, m_read_en,
    input  m_busy, m_done, m_status, m_data_out
  );

  modport master (
    output cmd_valid, cmd_rw, cmd_chip_addr, cmd_reg_addr, cmd_data,
    input  cmd_ready, cmd_level,
    input  rsp_valid, rsp_status, rsp_data, rsp_retries,
    output rsp_ready,
    input  m_chip_addr, m_reg_addr, m_data_in, m_write_en, m_read_en,
    output m_busy, m_done, m_status, m_data_out
  );
endinterface

// File: rtl/i2c_txn_sequencer.sv
// Queues I2C register transactions and issues them one at a time to i2c_master,
// handling NACK retry, per-transaction timeout and a single buffered response.
module i2c_txn_sequencer #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 8,
  parameter int MAX_RETRY = 2,
  parameter int TIMEOUT   = 4095
) (
  input  logic                clk,
  input  logic                reset,
  i2c_txn_sequencer_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int RET_W = $clog2(MAX_RETRY + 2);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [RET_W-1:0] RET_MAX  = RET_W'(MAX_RETRY);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_NACK = 2'd1;
  localparam logic [1:0] ST_TMO  = 2'd2;

  typedef struct packed {
    logic              rw;
    logic [6:0]        chip;
    logic [7:0]        rega;
    logic [DATA_W-1:0] data;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_SETTLE,
    S_RESP
  } state_t;

  cmd_t              mem_q [DEPTH];
  cmd_t              cmd_in;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  state_t            state_q, state_d;
  cmd_t              hold_q, hold_d;
  logic [TO_W-1:0]   tmo_q, tmo_d;
  logic [RET_W-1:0]  retry_q, retry_d;
  logic [1:0]        rsp_status_q, rsp_status_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]        rsp_retries_q, rsp_retries_d;
  logic              push;
  logic              pop;

  function automatic logic [1:0] sat_retries(input logic [RET_W-1:0] n);
    logic [31:0] w;
    w = 32'(n);
    return (w > 32'd3) ? 2'd3 : w[1:0];
  endfunction

  assign cmd_in = {bus.cmd_rw, bus.cmd_chip_addr, bus.cmd_reg_addr, bus.cmd_data};
  assign push   = bus.cmd_valid && (level_q != LVL_FULL);

  // Command FIFO: pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    tmo_d         = tmo_q;
    retry_d       = retry_q;
    rsp_status_d  = rsp_status_q;
    rsp_data_d    = rsp_data_q;
    rsp_retries_d = rsp_retries_q;
    pop           = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          hold_d  = mem_q[rd_ptr_q];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        // A done arriving in the deadline cycle is honoured ahead of the timeout.
        if (bus.m_done) begin
          if (bus.m_status == 4'h0) begin
            rsp_status_d  = ST_OK;
            rsp_data_d    = hold_q.rw ? bus.m_data_out : '0;
            rsp_retries_d = sat_retries(retry_q);
            state_d       = S_RESP;
          end else if (retry_q < RET_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = S_GAP;
          end else begin
            rsp_status_d  = ST_NACK;
            rsp_data_d    = '0;
            rsp_retries_d = sat_retries(retry_q);
            state_d       = S_RESP;
          end
        end else if (tmo_q == TO_LAST) begin
          rsp_status_d  = ST_TMO;
          rsp_data_d    = '0;
          rsp_retries_d = sat_retries(retry_q);
          state_d       = S_RESP;
        end
      end
      S_GAP: begin
        if (!bus.m_busy) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        state_d = S_ISSUE;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          retry_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      state_q       <= S_IDLE;
      hold_q        <= '0;
      tmo_q         <= '0;
      retry_q       <= '0;
      rsp_status_q  <= '0;
      rsp_data_q    <= '0;
      rsp_retries_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      state_q       <= state_d;
      hold_q        <= hold_d;
      tmo_q         <= tmo_d;
      retry_q       <= retry_d;
      rsp_status_q  <= rsp_status_d;
      rsp_data_q    <= rsp_data_d;
      rsp_retries_q <= rsp_retries_d;
    end
  end

  assign bus.cmd_ready   = (level_q != LVL_FULL);
  assign bus.cmd_level   = level_q;
  assign bus.rsp_valid   = (state_q == S_RESP);
  assign bus.rsp_status  = rsp_status_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_retries = rsp_retries_q;
  assign bus.m_chip_addr = hold_q.chip;
  assign bus.m_reg_addr  = hold_q.rega;
  assign bus.m_data_in   = hold_q.data;
  assign bus.m_write_en  = (state_q == S_ISSUE) && !hold_q.rw;
  assign bus.m_read_en   = (state_q == S_ISSUE) &&  hold_q.rw;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench for i2c_txn_sequencer: a behavioural i2c_master model on the
// default instance, plus a short-timeout instance driven by hand.
module tb_i2c_txn_sequencer;

  localparam int TO1 = 50;

  logic clk;
  logic reset;

  i2c_txn_sequencer_if #(.DATA_W(16), .DEPTH(8)) if0 ();
  i2c_txn_sequencer_if #(.DATA_W(16), .DEPTH(8)) if1 ();

  i2c_txn_sequencer #(.DATA_W(16), .DEPTH(8), .MAX_RETRY(2), .TIMEOUT(4095)) dut0 (
    .clk(clk), .reset(reset), .bus(if0)
  );

  i2c_txn_sequencer #(.DATA_W(16), .DEPTH(8), .MAX_RETRY(2), .TIMEOUT(TO1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1)
  );

  int          n_checks = 0;
  int          n_err    = 0;
  int          wr_pulses;
  int          rd_pulses;
  int          busy_cnt;
  int          nack_seen;
  int          cfg_lat   = 300;
  int          cfg_nacks = 0;
  bit          cfg_always = 1'b0;
  logic [15:0] cfg_rd    = 16'h5A5A;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // i2c_master model: busy for cfg_lat cycles after an enable, then one done pulse.
  initial begin
    busy_cnt = 0; wr_pulses = 0; rd_pulses = 0; nack_seen = 0;
    if0.m_busy = 1'b0; if0.m_done = 1'b0; if0.m_status = 4'h0; if0.m_data_out = 16'h0;
    forever begin
      @(posedge clk); #1;
      if0.m_done   = 1'b0;
      if0.m_status = 4'h0;
      if (reset) begin
        busy_cnt   = 0;
        if0.m_busy = 1'b0;
      end else begin
        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) begin
            if0.m_done     = 1'b1;
            if0.m_busy     = 1'b0;
            if0.m_data_out = cfg_rd;
            if (cfg_always || nack_seen < cfg_nacks) begin
              if0.m_status = 4'h1;
              nack_seen++;
            end else begin
              nack_seen = 0;
            end
          end
        end
        if (if0.m_write_en) wr_pulses++;
        if (if0.m_read_en)  rd_pulses++;
        if (if0.m_write_en || if0.m_read_en) begin
          busy_cnt   = cfg_lat;
          if0.m_busy = 1'b1;
        end
      end
    end
  end

  task automatic push0(input int rw, input int chip, input int rga, input int dat);
    bit ok;
    ok = 1'b0;
    if0.cmd_rw        = rw[0];
    if0.cmd_chip_addr = chip[6:0];
    if0.cmd_reg_addr  = rga[7:0];
    if0.cmd_data      = dat[15:0];
    if0.cmd_valid     = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      ok = if0.cmd_ready;
      @(negedge clk);
    end
    if0.cmd_valid = 1'b0;
    check("push accepted", 32'(ok), 1);
  endtask

  task automatic get_rsp(input string tag, input int st, input int dat, input int ret, input int din);
    int i;
    i = 0;
    while (!if0.rsp_valid && i < 3000) begin
      @(negedge clk);
      i++;
    end
    check({tag, " valid"},   32'(if0.rsp_valid), 1);
    check({tag, " status"},  32'(if0.rsp_status), st);
    check({tag, " data"},    32'(if0.rsp_data), dat);
    check({tag, " retries"}, 32'(if0.rsp_retries), ret);
    check({tag, " cmd"},     32'(if0.m_data_in), din);
    if0.rsp_ready = 1'b1;
    @(negedge clk);
    if0.rsp_ready = 1'b0;
    check({tag, " consumed"}, 32'(if0.rsp_valid), 0);
  endtask

  // Short-timeout instance: done_at>0 pulses m_done that many cycles after the enable.
  task automatic t1_txn(input string tag, input int done_at, input int exp_st);
    int lat;
    int i;
    if1.cmd_rw = 1'b0; if1.cmd_chip_addr = 7'h21; if1.cmd_reg_addr = 8'h05; if1.cmd_data = 16'h7777;
    if1.cmd_valid = 1'b1;
    @(negedge clk);
    if1.cmd_valid = 1'b0;
    i = 0;
    while (!if1.m_write_en && i < 20) begin
      @(negedge clk);
      i++;
    end
    check({tag, " enable"}, 32'(if1.m_write_en), 1);
    lat = 0;
    while (!if1.rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
      if1.m_done = (lat == done_at);
    end
    if1.m_done = 1'b0;
    check({tag, " latency"}, lat, (done_at > 0) ? done_at + 1 : TO1 + 1);
    check({tag, " status"},  32'(if1.rsp_status), exp_st);
    check({tag, " data"},    32'(if1.rsp_data), 0);
    check({tag, " retries"}, 32'(if1.rsp_retries), 0);
    if1.rsp_ready = 1'b1;
    @(negedge clk);
    if1.rsp_ready = 1'b0;
  endtask

  initial begin
    int w0;
    int r0;
    bit seen;
    reset = 1'b1;
    if0.cmd_valid = 1'b0; if0.cmd_rw = 1'b0; if0.cmd_chip_addr = '0; if0.cmd_reg_addr = '0;
    if0.cmd_data = '0; if0.rsp_ready = 1'b0;
    if1.cmd_valid = 1'b0; if1.cmd_rw = 1'b0; if1.cmd_chip_addr = '0; if1.cmd_reg_addr = '0;
    if1.cmd_data = '0; if1.rsp_ready = 1'b0;
    if1.m_busy = 1'b0; if1.m_done = 1'b0; if1.m_status = 4'h0; if1.m_data_out = 16'h0;
    repeat (3) @(negedge clk);

    check("rst cmd_ready",   32'(if0.cmd_ready), 1);
    check("rst cmd_level",   32'(if0.cmd_level), 0);
    check("rst rsp_valid",   32'(if0.rsp_valid), 0);
    check("rst rsp_status",  32'(if0.rsp_status), 0);
    check("rst rsp_data",    32'(if0.rsp_data), 0);
    check("rst rsp_retries", 32'(if0.rsp_retries), 0);
    check("rst enables",     32'({if0.m_write_en, if0.m_read_en}), 0);
    check("rst m_bus",       32'({if0.m_chip_addr, if0.m_reg_addr, if0.m_data_in}), 0);
    reset = 1'b0;
    @(negedge clk);

    // Write path, 300-cycle master latency.
    w0 = wr_pulses; r0 = rd_pulses;
    push0(0, 'h0F, 'h0A, 'hB2B2);
    check("wr no early pulse", 32'(if0.m_write_en), 0);
    @(negedge clk);
    check("wr pulse latency", 32'(if0.m_write_en), 1);
    check("wr no read pulse", 32'(if0.m_read_en), 0);
    check("wr m_chip_addr",   32'(if0.m_chip_addr), 'h0F);
    check("wr m_reg_addr",    32'(if0.m_reg_addr), 'h0A);
    get_rsp("wr rsp", 0, 0, 0, 'hB2B2);
    check("wr pulse count", wr_pulses - w0, 1);
    check("wr read count",  rd_pulses - r0, 0);

    // Read path.
    cfg_lat = 20; cfg_rd = 16'hC3C3;
    w0 = wr_pulses; r0 = rd_pulses;
    push0(1, 'h0F, 'h10, 'h1111);
    @(negedge clk);
    check("rd pulse latency", 32'(if0.m_read_en), 1);
    check("rd m_reg_addr",    32'(if0.m_reg_addr), 'h10);
    get_rsp("rd rsp", 0, 'hC3C3, 0, 'h1111);
    check("rd pulse count",  rd_pulses - r0, 1);
    check("rd write count",  wr_pulses - w0, 0);

    // Full FIFO with the response held.
    cfg_lat = 5;
    for (int i = 0; i < 9; i++) push0(0, 'h0F, 'h20 + i, 'h100 + i);
    if0.cmd_rw = 1'b0; if0.cmd_reg_addr = 8'h29; if0.cmd_data = 16'h0109; if0.cmd_valid = 1'b1;
    check("full cmd_ready", 32'(if0.cmd_ready), 0);
    check("full cmd_level", 32'(if0.cmd_level), 8);
    repeat (3) @(negedge clk);
    check("full still blocked", 32'(if0.cmd_ready), 0);
    if0.cmd_valid = 1'b0;
    for (int i = 0; i < 9; i++) get_rsp($sformatf("fifo rsp%0d", i), 0, 0, 0, 'h100 + i);
    check("drained level", 32'(if0.cmd_level), 0);

    // NACK twice then OK, then always NACK.
    cfg_lat = 10; cfg_nacks = 2;
    w0 = wr_pulses;
    push0(0, 'h0F, 'h40, 'h4444);
    get_rsp("nack2 rsp", 0, 0, 2, 'h4444);
    check("nack2 pulses", wr_pulses - w0, 3);
    cfg_nacks = 0; cfg_always = 1'b1;
    w0 = wr_pulses;
    push0(0, 'h0F, 'h41, 'h4545);
    get_rsp("nack rsp", 1, 0, 2, 'h4545);
    check("nack pulses", wr_pulses - w0, 3);
    cfg_always = 1'b0;

    // Timeout, then done exactly in the deadline cycle, then a normal one.
    t1_txn("tmo", 0, 2);
    t1_txn("done at deadline", TO1, 0);
    t1_txn("after tmo", 3, 0);

    // Asynchronous reset mid-WAIT with three commands queued.
    cfg_lat = 1000;
    w0 = wr_pulses;
    for (int i = 0; i < 4; i++) push0(0, 'h0F, 'h60 + i, 'h200 + i);
    repeat (2) @(negedge clk);
    check("pre-reset level", 32'(if0.cmd_level), 3);
    #2 reset = 1'b1;
    #1;
    check("async cmd_level", 32'(if0.cmd_level), 0);
    check("async cmd_ready", 32'(if0.cmd_ready), 1);
    check("async rsp_valid", 32'(if0.rsp_valid), 0);
    check("async m_bus",     32'({if0.m_chip_addr, if0.m_reg_addr, if0.m_data_in}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    if0.rsp_ready = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (if0.rsp_valid) seen = 1'b1;
    end
    if0.rsp_ready = 1'b0;
    check("abandoned no rsp", 32'(seen), 0);
    check("post-reset level", 32'(if0.cmd_level), 0);
    check("post-reset pulses", wr_pulses - w0, 1);
    cfg_lat = 5;
    push0(0, 'h0F, 'h33, 'hABCD);
    get_rsp("recovery rsp", 0, 0, 0, 'hABCD);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_txn_sequencer.md
Name: i2c_txn_sequencer

Overview:
- Queues complete I2C register transactions (write or read) and issues them one at a time to the existing i2c_master command interface.
- Owns NACK retry, per-transaction timeout and a buffered response channel, so system logic pushes commands without tracking master busy/done timing.
- Sits between the host/register logic and i2c_master.
- Generalises the single-shot write task of the write bench into a parametrised, depth-configurable, read/write hardware sequencer.

Parameters:
- DATA_W, 16: width of data_in/data_out on i2c_master; width of cmd_data and rsp_data.
- DEPTH, 8: command FIFO entries; power of 2, at least 2.
- MAX_RETRY, 2: re-issues after an error status before reporting failure; 0 means no retry.
- TIMEOUT, 4095: clk cycles from issue pulse to required m_done; must be at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full.
- cmd_rw  in  1  1=read, 0=write.
- cmd_chip_addr  in  7  target 7-bit address.
- cmd_reg_addr  in  8  register address.
- cmd_data  in  DATA_W  write data; ignored for reads.
- cmd_level  out  $clog2(DEPTH+1)  entries queued, excluding the one in flight.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  response consumed.
- rsp_status  out  2  0=OK, 1=NACK after retries, 2=timeout.
- rsp_data  out  DATA_W  read data; 0 for writes and failures.
- rsp_retries  out  2  retries used, saturating at 3.
- m_chip_addr  out  7  to i2c_master chip_addr.
- m_reg_addr  out  8  to i2c_master reg_addr.
- m_data_in  out  DATA_W  to i2c_master data_in.
- m_write_en  out  1  one-cycle write start pulse.
- m_read_en  out  1  one-cycle read start pulse.
- m_busy  in  1  from i2c_master busy.
- m_done  in  1  from i2c_master done, one-cycle pulse.
- m_status  in  4  from i2c_master status; nonzero at m_done means error.
- m_data_out  in  DATA_W  from i2c_master data_out; valid in the m_done cycle.

Behaviour:
- Reset (async assert, sync release): FIFO empty, FSM IDLE.
  - cmd_ready=1, cmd_level=0.
  - rsp_valid=0, rsp_status=0, rsp_data=0, rsp_retries=0.
  - m_write_en=0, m_read_en=0, m_* address/data outputs 0.
  - Reset mid-transaction abandons it: no response, queued commands discarded.
- Push: on cmd_valid&cmd_ready at an edge. Push while full is impossible (cmd_ready=0); the command is held by the producer.
- Simultaneous push and pop: cmd_level is unchanged.
- FSM IDLE: FIFO non-empty and rsp_valid=0 -> pop into the holding register, go to ISSUE. m_chip_addr/m_reg_addr/m_data_in update at pop and stay stable until the next pop.
- FSM ISSUE, one cycle: assert exactly one of m_write_en/m_read_en per rw; clear the timeout counter; go to WAIT.
- Latency: command pushed at edge N into an idle, empty block gives its enable pulse high in cycle N+1 to N+2 (pop at N+1, ISSUE registered at N+2).
- FSM WAIT: timeout counter increments each cycle.
  - m_done=1 and m_status==0 -> RESP with status 0; rsp_data=m_data_out for reads, 0 for writes.
  - m_done=1 and m_status!=0 and retries<MAX_RETRY -> increment retries, go to GAP.
  - m_done=1 and m_status!=0 with retries exhausted -> RESP with status 1.
  - Counter reaches TIMEOUT with no m_done -> RESP with status 2; no retry.
  - m_done in the same cycle the counter hits TIMEOUT: m_done wins.
- FSM GAP: wait until m_busy=0, plus one further cycle, then ISSUE the same command.
- FSM RESP: rsp_valid=1 with fields stable until rsp_ready=1. Handshake at an edge -> rsp_valid=0, retries cleared, IDLE.
- rsp_ready=1 while rsp_valid=0 has no effect.
- m_done seen in IDLE, ISSUE, GAP or RESP is ignored.
- No new issue while a response is unconsumed: single response buffer, backpressure propagates to cmd_ready once the FIFO fills.
- Pointers wrap modulo DEPTH; full when count==DEPTH.

Test Plan:
- Write path: push write chip 0x0F, reg 0x0A, data 0xB2B2; master model drives done with status 0 after 300 cycles -> one m_write_en pulse, m_reg_addr=0x0A, m_data_in=0xB2B2; rsp status 0, data 0, retries 0.
- Read path: push read reg 0x10; model returns 0xC3C3 -> one m_read_en pulse; rsp_data=0xC3C3, status 0.
- Full FIFO: hold rsp_ready=0, push 10 writes with DEPTH=8 -> first issues, then 8 accepted, cmd_ready=0 on the 10th, cmd_level=8. Release rsp_ready -> all 9 responses in push order.
- NACK retry: model returns status 4'h1 twice, then 0 -> three enable pulses; rsp status 0, retries 2. Always-NACK case -> three pulses, status 1.
- Timeout: TIMEOUT=50, model never pulses done -> rsp status 2 exactly 50 cycles after the enable pulse; next command then proceeds normally.
- Async reset mid-WAIT with 3 queued -> all outputs at reset values immediately; no response; cmd_level=0 after release.
